de_hazard_ctrl: RTL and testbench
=================================

DE_HAZARD_CTRL -- requirements
Module: de_hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, giving the number of stall cycles held after the branch-mispredict cycle (legal 1..7).
REQ-002 SHALL have parameter CNT_BITS, default 2, giving the width of each per-register pending-write counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port de_valid, input, 1 bit: the DE stage holds a valid instruction.
REQ-006 SHALL have ports de_use_rs1 and de_use_rs2, input, 1 bit each: the instruction reads rs1 and rs2 respectively.
REQ-007 SHALL have ports de_rs1 and de_rs2, input, 5 bits each: source register numbers.
REQ-008 SHALL have port de_wr_reg, input, 1 bit: the instruction writes a register.
REQ-009 SHALL have port de_rd, input, 5 bits: destination register number.
REQ-010 SHALL have port wb_wr_reg, input, 1 bit: the WB stage retires a register write this cycle.
REQ-011 SHALL have port wb_regno, input, 5 bits: the WB destination register.
REQ-012 SHALL have port br_mispred, input, 1 bit: AGEX reports a branch mispredict.
REQ-013 SHALL have port stall_out, output, 1 bit: stall to FE and DE; DE inserts a bubble.
REQ-014 SHALL have port issue_out, output, 1 bit: the DE instruction advances to AGEX this cycle.
REQ-015 SHALL have port busy_regs, output, 32 bits: bit i is high when counter i is nonzero.
REQ-016 SHALL have port err_underflow, output, 1 bit: sticky flag set by a WB retire to a register with no pending write.

Function
REQ-017 SHALL keep 32 pending-write counters of CNT_BITS width; counter 0 SHALL always read 0.
REQ-018 SHALL compute raw_hazard = (de_use_rs1 and rs1 != 0 and cnt[rs1] != 0) or the same condition for rs2.
REQ-019 SHALL compute struct_hazard = de_wr_reg and de_rd != 0 and cnt[de_rd] == all-ones; this prevents counter overflow.
REQ-020 SHALL drive stall_out = de_valid and (raw_hazard or struct_hazard), or br_mispred, or state == FLUSH; combinational, zero latency.
REQ-021 SHALL drive issue_out = de_valid and not stall_out.
REQ-022 SHALL increment cnt[de_rd] when issue_out, de_wr_reg and de_rd != 0 are all true.
REQ-023 SHALL decrement cnt[wb_regno] when wb_wr_reg is high and wb_regno != 0.
REQ-024 SHALL leave a counter unchanged when the increment and decrement hit the same register in the same cycle.
REQ-025 On a decrement of a zero counter, SHALL hold the counter at 0 and set err_underflow, which stays set until reset.
REQ-026 SHALL implement an FSM with two states:
  - RUN: on br_mispred, go to FLUSH and load flush_cnt = FLUSH_CYCLES-1.
  - FLUSH: decrement flush_cnt each cycle; go to RUN after the cycle in which flush_cnt == 0.
  - br_mispred during FLUSH: reload flush_cnt = FLUSH_CYCLES-1.
REQ-027 SHALL NOT change counters on a mispredict; squashed FE/DE instructions were never issued.
REQ-028 SHALL process WB decrements during FLUSH and during all stall cycles.

Reset
REQ-029 While reset is high, SHALL clear all counters, busy_regs and err_underflow, set state to RUN and flush_cnt to 0, and force stall_out=0 and issue_out=0.
REQ-030 Reset asserted mid-operation, including during FLUSH, SHALL take priority over every concurrent increment, decrement and mispredict.

Configuration
REQ-031 With macro HAZ_WB_BYPASS_EN defined, SHALL exclude a source from raw_hazard when wb_wr_reg is high, wb_regno equals that source, and its counter == 1; the register file written on the falling edge supplies the value.
REQ-032 Without HAZ_WB_BYPASS_EN, SHALL report raw_hazard until the counter has returned to 0, one cycle later than with the bypass.

Verification
REQ-033 Bench SHALL cover: issue ADDI x5 -> next cycle busy_regs[5]=1 and cnt[5]=1; then ADD x6,x5,x1 in DE -> stall_out=1, issue_out=0.
REQ-034 Bench SHALL cover: cnt[5]=1 with wb_wr_reg=1 and wb_regno=5 while DE reads x5 -> stall_out=0 with HAZ_WB_BYPASS_EN, stall_out=1 without it.
REQ-035 Bench SHALL cover: three issued writes to x7 followed by a fourth writer of x7 -> stall_out=1 (struct_hazard) and cnt[7] stays 3.
REQ-036 Bench SHALL cover: br_mispred pulsed one cycle with FLUSH_CYCLES=2 -> stall_out=1 for exactly 3 cycles, then issue_out=1 for a hazard-free instruction.
REQ-037 Bench SHALL cover: wb_wr_reg=1 with wb_regno=9 while cnt[9]=0 -> err_underflow=1 and cnt[9]=0; remains set until reset.
REQ-038 Bench SHALL cover: reset asserted during FLUSH with cnt[3]=2 -> next cycle busy_regs=0, state RUN, stall_out=0.

Source files
------------

// File: rtl/de_hazard_ctrl.sv
// Decode-stage hazard controller: per-register pending-write scoreboard, RAW/structural stall and mispredict flush.
// Optional HAZ_WB_BYPASS_EN: a source whose last pending write retires this cycle is not treated as a hazard.
module de_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_BITS     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        de_valid,
  input  logic        de_use_rs1,
  input  logic        de_use_rs2,
  input  logic [4:0]  de_rs1,
  input  logic [4:0]  de_rs2,
  input  logic        de_wr_reg,
  input  logic [4:0]  de_rd,
  input  logic        wb_wr_reg,
  input  logic [4:0]  wb_regno,
  input  logic        br_mispred,
  output logic        stall_out,
  output logic        issue_out,
  output logic [31:0] busy_regs,
  output logic        err_underflow
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  localparam logic [CNT_BITS-1:0] CNT_ONE    = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_MAX    = '1;
  localparam logic [2:0]          FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t              r_state;
  logic [2:0]          r_flush_cnt;
  logic                r_err;
  logic [CNT_BITS-1:0] w_cnt [32];
  logic [31:0]         w_busy;
  logic                w_byp1, w_byp2;
  logic                w_raw1, w_raw2, w_struct;
  logic                w_stall, w_issue;
  logic                w_inc_en, w_dec_en, w_underflow;

`ifdef HAZ_WB_BYPASS_EN
  // The register file is written on the falling edge, so the retiring value is readable this cycle.
  assign w_byp1 = wb_wr_reg && (wb_regno == de_rs1) && (w_cnt[de_rs1] == CNT_ONE);
  assign w_byp2 = wb_wr_reg && (wb_regno == de_rs2) && (w_cnt[de_rs2] == CNT_ONE);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign w_raw1   = de_use_rs1 && (de_rs1 != 5'd0) && (w_cnt[de_rs1] != '0) && !w_byp1;
  assign w_raw2   = de_use_rs2 && (de_rs2 != 5'd0) && (w_cnt[de_rs2] != '0) && !w_byp2;
  assign w_struct = de_wr_reg && (de_rd != 5'd0) && (w_cnt[de_rd] == CNT_MAX);

  assign w_stall = !reset && ((de_valid && (w_raw1 || w_raw2 || w_struct)) ||
                              br_mispred || (r_state == ST_FLUSH));
  assign w_issue = !reset && de_valid && !w_stall;

  assign w_inc_en    = w_issue && de_wr_reg && (de_rd != 5'd0);
  assign w_dec_en    = wb_wr_reg && (wb_regno != 5'd0);
  assign w_underflow = w_dec_en && (w_cnt[wb_regno] == '0);

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign w_cnt[gi]  = '0;
        assign w_busy[gi] = 1'b0;
      end else begin : g_cnt
        logic [CNT_BITS-1:0] r_cnt;
        logic                w_inc, w_dec;

        assign w_inc = w_inc_en && (de_rd == 5'(gi));
        assign w_dec = w_dec_en && (wb_regno == 5'(gi));

        // Simultaneous issue and retire to the same register cancel out.
        always_ff @(posedge clk) begin
          if (reset) begin
            r_cnt <= '0;
          end else if (w_inc && !w_dec) begin
            r_cnt <= r_cnt + CNT_ONE;
          end else if (w_dec && !w_inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        assign w_cnt[gi]  = r_cnt;
        assign w_busy[gi] = (r_cnt != '0);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 3'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (br_mispred) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= FLUSH_LOAD;
          end
        end
        ST_FLUSH: begin
          if (br_mispred) begin
            r_flush_cnt <= FLUSH_LOAD;
          end else if (r_flush_cnt == 3'd0) begin
            r_state <= ST_RUN;
          end else begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
          end
        end
        default: begin
          r_state     <= ST_RUN;
          r_flush_cnt <= 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_underflow) begin
      r_err <= 1'b1;
    end
  end

  assign stall_out     = w_stall;
  assign issue_out     = w_issue;
  assign busy_regs     = reset ? 32'd0 : w_busy;
  assign err_underflow = r_err && !reset;

endmodule

// File: tb/tb_de_hazard_ctrl.sv
// Self-checking bench for de_hazard_ctrl: directed scenarios then random traffic against a scoreboard model.
module tb_de_hazard_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_BITS     = 2;
  localparam int CNT_MAX      = (1 << CNT_BITS) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        de_valid, de_use_rs1, de_use_rs2, de_wr_reg;
  logic [4:0]  de_rs1, de_rs2, de_rd;
  logic        wb_wr_reg;
  logic [4:0]  wb_regno;
  logic        br_mispred;
  logic        stall_out, issue_out, err_underflow;
  logic [31:0] busy_regs;

  int m_cnt [32];
  int m_flush;
  bit m_err;
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  de_hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_BITS(CNT_BITS)) dut (
    .clk(clk), .reset(reset), .de_valid(de_valid),
    .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2),
    .de_rs1(de_rs1), .de_rs2(de_rs2), .de_wr_reg(de_wr_reg), .de_rd(de_rd),
    .wb_wr_reg(wb_wr_reg), .wb_regno(wb_regno), .br_mispred(br_mispred),
    .stall_out(stall_out), .issue_out(issue_out),
    .busy_regs(busy_regs), .err_underflow(err_underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A source blocks issue while any write to it is still outstanding.
  function automatic bit src_busy(input logic [4:0] r);
    if (r == 5'd0 || m_cnt[r] == 0) return 1'b0;
`ifdef HAZ_WB_BYPASS_EN
    if (wb_wr_reg && wb_regno == r && m_cnt[r] == 1) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic set_de(input logic v, input logic u1, input int r1, input logic u2,
                        input int r2, input logic wr, input int rd);
    de_valid = v; de_use_rs1 = u1; de_rs1 = 5'(r1);
    de_use_rs2 = u2; de_rs2 = 5'(r2); de_wr_reg = wr; de_rd = 5'(rd);
  endtask

  task automatic set_wb(input logic wr, input int r);
    wb_wr_reg = wr; wb_regno = 5'(r);
  endtask

  // Check outputs against the model, then advance one clock and update the model.
  task automatic step(input string tag);
    bit          hz, e_stall, e_issue, e_err, inc, dec;
    logic [31:0] e_busy;
    #1;
    hz = (de_use_rs1 && src_busy(de_rs1)) || (de_use_rs2 && src_busy(de_rs2)) ||
         (de_wr_reg && de_rd != 5'd0 && m_cnt[de_rd] == CNT_MAX);
    e_stall = (de_valid && hz) || br_mispred || (m_flush > 0);
    e_issue = de_valid && !e_stall;
    e_busy  = '0;
    for (int i = 1; i < 32; i++) e_busy[i] = (m_cnt[i] > 0);
    e_err = m_err;
    if (reset) begin
      e_stall = 1'b0; e_issue = 1'b0; e_busy = '0; e_err = 1'b0;
    end
    check({tag, ".stall"}, 32'(stall_out), 32'(e_stall));
    check({tag, ".issue"}, 32'(issue_out), 32'(e_issue));
    check({tag, ".busy"}, busy_regs, e_busy);
    check({tag, ".err"}, 32'(err_underflow), 32'(e_err));
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_flush = 0;
      m_err   = 1'b0;
    end else begin
      inc = e_issue && de_wr_reg && de_rd != 5'd0;
      dec = wb_wr_reg && wb_regno != 5'd0;
      if (dec && m_cnt[wb_regno] == 0) m_err = 1'b1;
      if (!(inc && dec && de_rd == wb_regno)) begin
        if (inc) m_cnt[de_rd]++;
        if (dec && m_cnt[wb_regno] > 0) m_cnt[wb_regno]--;
      end
      if (br_mispred) m_flush = FLUSH_CYCLES;
      else if (m_flush > 0) m_flush--;
    end
    @(negedge clk);
  endtask

  initial begin
    int n_stall;
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_flush = 0;
    m_err   = 1'b0;
    reset = 1'b1; br_mispred = 1'b0;
    set_de(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
    @(negedge clk);
    step("rst0");
    step("rst1");
    reset = 1'b0;

    // ADDI x5 then dependent ADD x6,x5,x1
    set_de(1, 1, 0, 0, 0, 1, 5);
    #1 check("addi_issue", 32'(issue_out), 32'd1);
    step("addi");
    set_de(1, 1, 5, 1, 1, 1, 6);
    #1 check("x5_busy", 32'(busy_regs[5]), 32'd1);
    check("add_stall", 32'(stall_out), 32'd1);
    check("add_noissue", 32'(issue_out), 32'd0);
    step("add_wait");

    // x5 retires while ADD waits in DE
    set_wb(1, 5);
`ifdef HAZ_WB_BYPASS_EN
    #1 check("bypass_stall", 32'(stall_out), 32'd0);
`else
    #1 check("bypass_stall", 32'(stall_out), 32'd1);
`endif
    step("wb5");
    set_wb(0, 0);
    step("add_after_wb");
    set_de(0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 6);
    step("wb6");
    set_wb(0, 0);

    // Three writers of x7 fill the counter; the fourth must wait
    set_de(1, 0, 0, 0, 0, 1, 7);
    for (int k = 0; k < 3; k++) step("x7_wr");
    #1 check("x7_struct_stall", 32'(stall_out), 32'd1);
    step("x7_fourth");
    step("x7_fourth_hold");
    set_de(0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 7);
    step("x7_drain0");
    step("x7_drain1");
    #1 check("x7_still_busy", 32'(busy_regs[7]), 32'd1);
    step("x7_drain2");
    set_wb(0, 0);
    #1 check("x7_clear", 32'(busy_regs[7]), 32'd0);
    check("x7_no_underflow", 32'(err_underflow), 32'd0);
    step("x7_done");

    // Mispredict pulse: three stall cycles, then a clean instruction issues
    set_de(1, 1, 1, 1, 2, 1, 10);
    br_mispred = 1'b1;
    n_stall = 0;
    for (int k = 0; k < 4; k++) begin
      #1 if (stall_out) n_stall++;
      step("flush");
      br_mispred = 1'b0;
      if (k == 2) #1 check("flush_issue", 32'(issue_out), 32'd1);
    end
    check("flush_len", 32'(n_stall), 32'd3);
    set_de(0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 10);
    step("wb10");

    // Retire to an idle register
    set_wb(1, 9);
    step("under");
    set_wb(0, 0);
    #1 check("under_err", 32'(err_underflow), 32'd1);
    check("under_x9", 32'(busy_regs[9]), 32'd0);
    step("under_hold0");
    step("under_hold1");

    // Reset in the middle of a flush with two writes to x3 outstanding
    set_de(1, 0, 0, 0, 0, 1, 3);
    step("x3_a");
    step("x3_b");
    set_de(0, 0, 0, 0, 0, 0, 0);
    br_mispred = 1'b1;
    step("mp");
    br_mispred = 1'b0;
    step("in_flush");
    reset = 1'b1;
    step("rst_flush");
    reset = 1'b0;
    set_de(1, 1, 3, 0, 0, 0, 0);
    #1 check("rst_busy", busy_regs, 32'd0);
    check("rst_stall", 32'(stall_out), 32'd0);
    check("rst_issue", 32'(issue_out), 32'd1);
    step("after_rst");

    // Random traffic on a small register window to force collisions
    for (int k = 0; k < 500; k++) begin
      reset      = ($urandom_range(99) == 0);
      br_mispred = ($urandom_range(15) == 0);
      set_de($urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(7),
             $urandom_range(1) == 1, $urandom_range(7), $urandom_range(3) != 0,
             $urandom_range(7));
      set_wb($urandom_range(2) == 0, $urandom_range(7));
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
